mem_stage: RTL and testbench

//  Memory stage of the 5-stage MIPS pipeline, between exe_stage and wb_stage. Consumes es_to_ms_bus, matches
//  in-order data-bus responses (data_ok) to memory instructions, aligns and extends load data (lb/lbu/lh/lhu/lw/lwl/lwr),

---
 rtl/mem_stage.sv | 215 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage MIPS pipeline (between exe_stage and wb_stage).
// Matches in-order data-bus responses to memory instructions and buffers them
// in a small FIFO. Aligns and extends load data. Drives the forward/interlock
// bus and drops responses that belong to flushed accesses.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   ws_allowin           WB can accept;           ms_allowin      MS can accept
//   es_to_ms_valid/_bus  instruction from ES;     ms_to_ws_valid/_bus  to WB
//   data_sram_req/addr_ok  request accepted (counted as in flight)
//   data_sram_data_ok/rdata  in-order response, word-lane aligned
//   ms_fwd_bus           {mfc0, load_pending, block_valid, dest, result}
//   ms_ex                valid MS instruction carries an exception
//   flush                exception/eret flush from WB
module mem_stage #(
  parameter int unsigned ES_TO_MS_BUS_WD = 129,
  parameter int unsigned MS_TO_WS_BUS_WD = 123,
  parameter int unsigned MS_FWD_BUS_WD   = 40,
  parameter int unsigned RESP_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_req,
  input  logic                       data_sram_addr_ok,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
  output logic                       ms_ex,
  input  logic                       flush
);

  localparam int unsigned PtrW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);

  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus_q, ms_bus_d;
  logic [1:0]                 inflight_q, inflight_d;
  logic [1:0]                 discard_q, discard_d;
  logic [31:0]                buf_q [RESP_DEPTH];
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]            cnt_q, cnt_d;

  // Fields of the held instruction
  logic        store_op, bd, ex, res_from_mem, gr_we;
  logic [31:0] badvaddr, res, pc;
  logic [10:0] c0_bus;
  logic [4:0]  excode, dest;
  logic [6:0]  ld_inst;
  logic [1:0]  addr_lo;

  assign store_op     = ms_bus_q[128];
  assign badvaddr     = ms_bus_q[127:96];
  assign c0_bus       = ms_bus_q[95:85];
  assign bd           = ms_bus_q[84];
  assign ex           = ms_bus_q[83];
  assign excode       = ms_bus_q[82:78];
  assign ld_inst      = ms_bus_q[77:71];
  assign res_from_mem = ms_bus_q[70];
  assign gr_we        = ms_bus_q[69];
  assign dest         = ms_bus_q[68:64];
  assign res          = ms_bus_q[63:32];
  assign pc           = ms_bus_q[31:0];
  assign addr_lo      = res[1:0];

  logic        req_accept, resp_live, resp_drop, buf_empty, buf_full;
  logic        mem_op, ms_ready_go, resp_pop, bypass, push, pop_buf;
  logic [31:0] ld_word;

  always_comb begin
    req_accept     = data_sram_req && data_sram_addr_ok;
    resp_live      = data_sram_data_ok && (discard_q == 2'd0);
    resp_drop      = data_sram_data_ok && (discard_q != 2'd0);
    buf_empty      = (cnt_q == '0);
    buf_full       = (cnt_q == CntW'(RESP_DEPTH));
    mem_op         = res_from_mem || store_op;
    ms_ready_go    = !mem_op || ex || !buf_empty || resp_live;
    ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
    // A faultless memory op leaving MS consumes exactly one response.
    resp_pop       = ms_to_ws_valid && ws_allowin && mem_op && !ex;
    // Empty buffer: the arriving response is consumed directly, never stored.
    bypass         = resp_pop && buf_empty;
    push           = resp_live && !bypass && !flush;
    pop_buf        = resp_pop && !buf_empty;
    ld_word        = buf_empty ? data_sram_rdata : buf_q[rd_ptr_q];
  end

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    ms_bus_d = (ms_allowin && es_to_ms_valid) ? es_to_ms_bus : ms_bus_q;

    inflight_d = inflight_q + 2'(req_accept) - 2'(data_sram_data_ok);
    // On flush every response still owed after this edge belongs to a killed access.
    discard_d  = flush ? inflight_d : discard_q - 2'(resp_drop);

    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      cnt_d    = cnt_q + CntW'(push) - CntW'(pop_buf);
      rd_ptr_d = rd_ptr_q + PtrW'(pop_buf);
      wr_ptr_d = wr_ptr_q + PtrW'(push);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
      ms_bus_q   <= '0;
      inflight_q <= 2'd0;
      discard_q  <= 2'd0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      ms_bus_q   <= ms_bus_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(RESP_DEPTH); i++) buf_q[i] <= '0;
    end else if (push) begin
      buf_q[wr_ptr_q] <= data_sram_rdata;
    end
  end

  // Load alignment and extension
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  ld_wen;

  always_comb begin
    unique case (addr_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    ld_wen  = 4'b1111;
    if (ld_inst[5]) begin
      ld_data = {{24{ld_byte[7]}}, ld_byte};
    end else if (ld_inst[4]) begin
      ld_data = {24'h0, ld_byte};
    end else if (ld_inst[3]) begin
      ld_data = {{16{ld_half[15]}}, ld_half};
    end else if (ld_inst[2]) begin
      ld_data = {16'h0, ld_half};
    end else if (ld_inst[1]) begin
      unique case (addr_lo)
        2'd0: begin ld_data = {ld_word[7:0], 24'h0};  ld_wen = 4'b1000; end
        2'd1: begin ld_data = {ld_word[15:0], 16'h0}; ld_wen = 4'b1100; end
        2'd2: begin ld_data = {ld_word[23:0], 8'h0};  ld_wen = 4'b1110; end
        default: begin ld_data = ld_word;             ld_wen = 4'b1111; end
      endcase
    end else if (ld_inst[0]) begin
      unique case (addr_lo)
        2'd0: begin ld_data = ld_word;                 ld_wen = 4'b1111; end
        2'd1: begin ld_data = {8'h0, ld_word[31:8]};   ld_wen = 4'b0111; end
        2'd2: begin ld_data = {16'h0, ld_word[31:16]}; ld_wen = 4'b0011; end
        default: begin ld_data = {24'h0, ld_word[31:24]}; ld_wen = 4'b0001; end
      endcase
    end
  end

  logic [31:0] final_result;
  logic [3:0]  rf_wen;

  always_comb begin
    final_result = res_from_mem ? ld_data : res;
    if (!ms_valid_q || ex) begin
      rf_wen = 4'b0000;
    end else if (res_from_mem) begin
      rf_wen = ld_wen;
    end else begin
      rf_wen = {4{gr_we}};
    end
    ms_to_ws_bus = {c0_bus, bd, ex, excode, badvaddr, rf_wen, dest, final_result, pc};
    ms_fwd_bus   = {c0_bus[8] && ms_valid_q,
                    ms_valid_q && res_from_mem && !ms_ready_go,
                    ms_valid_q && gr_we && !flush,
                    dest, final_result};
    ms_ex        = ms_valid_q && ex;
  end

`ifndef SYNTHESIS
  resp_overflow_a: assert property (@(posedge clk) disable iff (!resetn)
    !(buf_full && push && !pop_buf));
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic         clk = 1'b0;
  logic         resetn, ws_allowin, es_to_ms_valid, flush;
  logic [128:0] es_to_ms_bus;
  logic         data_sram_req, data_sram_addr_ok, data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ms_allowin, ms_to_ws_valid, ms_ex;
  logic [122:0] ms_to_ws_bus;
  logic [39:0]  ms_fwd_bus;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_req(data_sram_req), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms_fwd_bus(ms_fwd_bus), .ms_ex(ms_ex), .flush(flush)
  );

  localparam logic [6:0] LW = 7'b1000000, LB = 7'b0100000, LBU = 7'b0010000, LH = 7'b0001000,
                         LHU = 7'b0000100, LWL = 7'b0000010, LWR = 7'b0000001;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: held instruction, queue of unconsumed responses, counters
  bit           m_valid;
  logic [128:0] m_bus;
  logic [31:0]  rq[$];
  int           m_inflight, m_discard;

  logic         e_allowin, e_ws_valid, e_ready, e_ex, e_mfc0, e_pend, e_block, e_chk_res;
  logic [122:0] e_bus;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [128:0] mk_bus(logic st, logic [31:0] badv, logic [10:0] c0, logic bd,
      logic ex, logic [4:0] exc, logic [6:0] ld, logic rfm, logic gr, logic [4:0] dst,
      logic [31:0] res, logic [31:0] pc);
    return {st, badv, c0, bd, ex, exc, ld, rfm, gr, dst, res, pc};
  endfunction

  function automatic logic [128:0] mk_ld(logic [6:0] ld, logic [31:0] addr, logic ex,
      logic [4:0] exc);
    return mk_bus(1'b0, addr, 11'h0, 1'b0, ex, exc, ld, 1'b1, 1'b1, 5'd3, addr,
                  32'hBFC0_0000 + addr);
  endfunction

  function automatic logic [128:0] rand_bus();
    int          kind = $urandom_range(3);
    logic [6:0]  ld   = 7'(7'd1 << $urandom_range(6));
    logic        ex   = ($urandom_range(9) == 0);
    logic [31:0] addr = $urandom;
    logic [10:0] c0   = 11'($urandom);
    logic        rfm  = (kind < 2);
    logic        st   = (kind == 2);
    logic        gr   = (kind < 2) || (kind == 3 && $urandom_range(1) == 1);
    if (!rfm) ld = 7'h0;
    return mk_bus(st, addr, c0, ($urandom_range(1) == 1), ex, 5'($urandom), ld, rfm, gr,
                  5'($urandom), addr, $urandom);
  endfunction

  // {wen, data} of a load from the byte-lane rules
  function automatic logic [35:0] model_align(logic [6:0] ld, logic [1:0] a, logic [31:0] w);
    logic [7:0]  by = 8'(w >> (8 * a));
    logic [15:0] hw = 16'(w >> (16 * a[1]));
    case (ld)
      LB:      return {4'hf, 32'($signed(by))};
      LBU:     return {4'hf, 32'(by)};
      LH:      return {4'hf, 32'($signed(hw))};
      LHU:     return {4'hf, 32'(hw)};
      LWL:     return {4'(4'hf << (3 - a)), 32'(w << (8 * (3 - a)))};
      LWR:     return {4'(4'hf >> a), 32'(w >> (8 * a))};
      default: return {4'hf, w};
    endcase
  endfunction

  task automatic model_reset();
    m_valid    = 1'b0;
    m_bus      = '0;
    rq.delete();
    m_inflight = 0;
    m_discard  = 0;
  endtask

  task automatic model_eval();
    logic        rfm = m_bus[70];
    logic        ex  = m_bus[83];
    logic        mem = m_bus[70] || m_bus[128];
    logic        live = data_sram_data_ok && (m_discard == 0);
    logic [31:0] w;
    logic [35:0] al;
    logic [3:0]  wen;
    logic [31:0] result;
    w          = (rq.size() > 0) ? rq[0] : data_sram_rdata;
    al         = model_align(m_bus[77:71], m_bus[33:32], w);
    e_ready    = !mem || ex || (rq.size() > 0) || live;
    e_allowin  = !m_valid || (e_ready && ws_allowin);
    e_ws_valid = m_valid && e_ready && !flush;
    e_ex       = m_valid && ex;
    e_mfc0     = m_valid && m_bus[93];
    e_pend     = m_valid && rfm && !e_ready;
    e_block    = m_valid && m_bus[69] && !flush;
    e_chk_res  = !(rfm && ex);
    result     = rfm ? al[31:0] : m_bus[63:32];
    if (!m_valid || ex) wen = 4'h0;
    else if (rfm)       wen = al[35:32];
    else                wen = {4{m_bus[69]}};
    e_bus = {m_bus[95:85], m_bus[84], m_bus[83], m_bus[82:78], m_bus[127:96], wen,
             m_bus[68:64], result, m_bus[31:0]};
  endtask

  task automatic model_check();
    chk("allowin", 128'(ms_allowin), 128'(e_allowin));
    chk("ws_valid", 128'(ms_to_ws_valid), 128'(e_ws_valid));
    chk("ms_ex", 128'(ms_ex), 128'(e_ex));
    chk("fwd_flags", 128'(ms_fwd_bus[39:37]), 128'({e_mfc0, e_pend, e_block}));
    if (e_ws_valid) begin
      chk("bus_ctl", 128'(ms_to_ws_bus[122:64]), 128'(e_bus[122:64]));
      chk("bus_pc", 128'(ms_to_ws_bus[31:0]), 128'(e_bus[31:0]));
      if (e_chk_res) chk("bus_result", 128'(ms_to_ws_bus[63:32]), 128'(e_bus[63:32]));
    end
    if (e_block) begin
      chk("fwd_dest", 128'(ms_fwd_bus[36:32]), 128'(e_bus[68:64]));
      if (e_ready && e_chk_res) chk("fwd_result", 128'(ms_fwd_bus[31:0]), 128'(e_bus[63:32]));
    end
  endtask

  task automatic model_update();
    int acc = (data_sram_req && data_sram_addr_ok) ? 1 : 0;
    int dok = data_sram_data_ok ? 1 : 0;
    bit mem = m_bus[70] || m_bus[128];
    bit consume = e_ws_valid && ws_allowin && mem && !m_bus[83];
    m_inflight = m_inflight + acc - dok;
    if (flush) begin
      rq.delete();
      m_discard = m_inflight;
      m_valid   = 1'b0;
    end else begin
      if (data_sram_data_ok) begin
        if (m_discard > 0) m_discard--;
        else rq.push_back(data_sram_rdata);
      end
      if (consume) void'(rq.pop_front());
      if (e_allowin) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) m_bus = es_to_ms_bus;
      end
    end
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
  task automatic tick();
    #1;
    if (!resetn) model_reset();
    model_eval();
    model_check();
    if (resetn) model_update();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    resetn            = 1'b1;
    ws_allowin        = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    flush             = 1'b0;
    data_sram_req     = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
  endtask

  task automatic load_case(string nm, logic [6:0] ld, logic [31:0] addr, logic [31:0] rd,
      logic [31:0] exp_res, logic [3:0] exp_wen);
    drive_idle();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_ld(ld, addr, 1'b0, 5'd0);
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    tick();
    drive_idle();
    data_sram_data_ok = 1'b1; data_sram_rdata = rd;
    #1;
    chk({nm, "_valid"}, 128'(ms_to_ws_valid), 128'(1));
    chk({nm, "_res"}, 128'(ms_to_ws_bus[63:32]), 128'(exp_res));
    chk({nm, "_wen"}, 128'(ms_to_ws_bus[72:69]), 128'(exp_wen));
    tick();
    drive_idle();
    #1;
    chk({nm, "_gone"}, 128'(ms_to_ws_valid), 128'(0));
    tick();
  endtask

  initial begin
    drive_idle();
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_allowin", 128'(ms_allowin), 128'(1));
    chk("rst_valid", 128'(ms_to_ws_valid), 128'(0));
    chk("rst_bus", 128'(ms_to_ws_bus), 128'(0));
    chk("rst_fwd", 128'(ms_fwd_bus), 128'(0));
    chk("rst_ex", 128'(ms_ex), 128'(0));
    tick();
    tick();
    drive_idle();

    load_case("lw",  LW,  32'h100, 32'h8899AABB, 32'h8899AABB, 4'b1111);
    load_case("lb",  LB,  32'h103, 32'h80112233, 32'hFFFFFF80, 4'b1111);
    load_case("lbu", LBU, 32'h103, 32'h80112233, 32'h00000080, 4'b1111);
    load_case("lh",  LH,  32'h102, 32'h80112233, 32'hFFFF8011, 4'b1111);
    load_case("lhu", LHU, 32'h102, 32'h80112233, 32'h00008011, 4'b1111);
    load_case("lwl", LWL, 32'h101, 32'h11223344, 32'h33440000, 4'b1100);
    load_case("lwr", LWR, 32'h102, 32'h11223344, 32'h00001122, 4'b0011);

    // Back-pressure: two responses buffered while WB stalls
    drive_idle();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk_ld(LW, 32'h200, 1'b0, 5'd0);
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    tick();
    drive_idle();
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk_ld(LW, 32'h204, 1'b0, 5'd0);
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    #1; chk("bp_allowin0", 128'(ms_allowin), 128'(0));
    tick();
    data_sram_req = 1'b0; data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hA1A1A1A1;
    #1; chk("bp_allowin1", 128'(ms_allowin), 128'(0));
    tick();
    data_sram_rdata = 32'hB2B2B2B2;
    #1; chk("bp_allowin2", 128'(ms_allowin), 128'(0));
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    #1; chk("bp_allowin3", 128'(ms_allowin), 128'(0));
    tick();
    ws_allowin = 1'b1;
    #1; chk("bp_first", 128'(ms_to_ws_bus[63:32]), 128'(32'hA1A1A1A1));
    tick();
    es_to_ms_valid = 1'b0;
    #1; chk("bp_second_v", 128'(ms_to_ws_valid), 128'(1));
    chk("bp_second", 128'(ms_to_ws_bus[63:32]), 128'(32'hB2B2B2B2));
    tick();
    drive_idle();
    tick();

    // Flush with two responses outstanding
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk_ld(LW, 32'h300, 1'b0, 5'd0);
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    tick();
    drive_idle();
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    tick();
    drive_idle();
    flush = 1'b1;
    #1; chk("fl_valid", 128'(ms_to_ws_valid), 128'(0));
    tick();
    drive_idle();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD0001;
    #1; chk("fl_empty", 128'(ms_allowin), 128'(1));
    tick();
    data_sram_rdata = 32'hDEAD0002;
    tick();
    drive_idle();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk_ld(LW, 32'h310, 1'b0, 5'd0);
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    tick();
    drive_idle();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h600DF00D;
    #1; chk("fl_third_v", 128'(ms_to_ws_valid), 128'(1));
    chk("fl_third", 128'(ms_to_ws_bus[63:32]), 128'(32'h600DF00D));
    tick();
    drive_idle();
    tick();

    // Load carrying an address-error exception
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk_ld(LW, 32'h401, 1'b1, 5'd4);
    tick();
    drive_idle();
    #1;
    chk("ex_valid", 128'(ms_to_ws_valid), 128'(1));
    chk("ex_wen", 128'(ms_to_ws_bus[72:69]), 128'(0));
    chk("ex_flag", 128'(ms_ex), 128'(1));
    chk("ex_code", 128'(ms_to_ws_bus[109:105]), 128'(4));
    tick();

    // Reset while a load waits for its response
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk_ld(LW, 32'h500, 1'b0, 5'd0);
    data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    tick();
    drive_idle();
    #1; chk("rm_pending", 128'(ms_fwd_bus[38]), 128'(1));
    resetn = 1'b0;
    #1;
    chk("rm_allowin", 128'(ms_allowin), 128'(1));
    chk("rm_valid", 128'(ms_to_ws_valid), 128'(0));
    chk("rm_fwd", 128'(ms_fwd_bus), 128'(0));
    chk("rm_ex", 128'(ms_ex), 128'(0));
    tick();
    drive_idle();
    tick();

    // Randomized traffic under protocol constraints
    for (int c = 0; c < 3000; c++) begin
      resetn            = 1'b1;
      flush             = ($urandom_range(39) == 0);
      ws_allowin        = ($urandom_range(3) != 0);
      es_to_ms_valid    = ($urandom_range(2) != 0);
      es_to_ms_bus      = rand_bus();
      data_sram_req     = ($urandom_range(1) == 1);
      data_sram_addr_ok = (m_inflight < 3) && ($urandom_range(1) == 1);
      data_sram_data_ok = (m_inflight > 0) && (m_discard > 0 || rq.size() < 2) &&
                          ($urandom_range(2) != 0);
      data_sram_rdata   = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
